ps2_tx_apb: RTL



---
 rtl/ps2_tx_apb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_tx_apb.sv
// APB-fed PS/2 device-side transmitter: 16-deep byte FIFO, 11-bit framed serialiser.
// Build option PS2_TX_PARERR_EN adds a CTRL register that injects one bad-parity frame.
module ps2_tx_apb #(
    parameter int CLK_DIV = 8,
    parameter int GAP_CYC = 32,
    parameter int FIFO_AW = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic        ps2_clk,
    output logic        ps2_data
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW = FIFO_AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_GAP} state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [CW-1:0]      r_count;
    state_t             r_state;
    logic [DW-1:0]      r_div;
    logic [3:0]         r_bit;
    logic [GW-1:0]      r_gap;
    logic [9:0]         r_frame;
    logic               r_inj;

    logic        w_acc;
    logic [1:0]  w_sel;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_byte;
    logic        w_par;
    logic        w_div_end;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_acc     = in_psel & in_penable;
    assign w_sel     = in_paddr[3:2];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_state != S_IDLE);
    assign w_push    = w_acc & in_pwrite & (w_sel == 2'd0) & in_pstrb[0] & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_byte    = r_mem[r_rptr];
    assign w_par     = ~^w_byte ^ r_inj;
    assign w_div_end = (r_div == DW'(CLK_DIV - 1));
    assign w_status  = (32'(r_count) << 8) | {29'b0, w_busy, w_full, w_empty};
    assign w_unused  = ^{in_pprot, in_paddr[31:4], in_paddr[1:0],
                        in_pwdata[31:8], in_pstrb[3:1]};

    always_comb begin
        w_rdata = '0;
        if (w_acc && !in_pwrite) begin
            case (w_sel)
                2'd1:    w_rdata = w_status;
`ifdef PS2_TX_PARERR_EN
                2'd2:    w_rdata = {31'b0, r_inj};
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    assign in_pready  = w_acc;
    assign in_prdata  = w_rdata;
    assign in_pslverr = w_acc & in_pwrite & (w_sel == 2'd0) & in_pstrb[0] & w_full;

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= in_pwdata[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PS2_TX_PARERR_EN
    // A same-cycle software write overrides the self-clear on pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inj <= 1'b0;
        end else if (w_acc && in_pwrite && w_sel == 2'd2) begin
            r_inj <= in_pwdata[0];
        end else if (w_pop) begin
            r_inj <= 1'b0;
        end
    end
`else
    assign r_inj = 1'b0;
`endif

    // r_frame holds the bits still to send after the start bit, LSB next
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_gap    <= '0;
            r_frame  <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_frame  <= {1'b1, w_par, w_byte};
                        r_bit    <= '0;
                        r_div    <= '0;
                        r_state  <= S_HI;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b0;
                    end
                end
                S_HI: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_state <= S_LO;
                        ps2_clk <= 1'b0;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LO: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        ps2_clk <= 1'b1;
                        if (r_bit == 4'd10) begin
                            r_gap    <= '0;
                            r_state  <= S_GAP;
                            ps2_data <= 1'b1;
                        end else begin
                            r_bit    <= r_bit + 1'b1;
                            r_state  <= S_HI;
                            ps2_data <= r_frame[0];
                            r_frame  <= {1'b1, r_frame[9:1]};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(GAP_CYC - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
